vpix_fetch: RTL and testbench
=============================

VPIX_FETCH -- requirements
Module: vpix_fetch

Interface
REQ-001 SHALL have parameter AWIDTH, default 16, width of video memory byte address.
REQ-002 SHALL have parameter PWIDTH, default 6, pixel width (RGB222); four pixels are packed in three bytes.
REQ-003 SHALL have port PixelClk  input  1  pixel clock; sole clock, all state on rising edge.
REQ-004 SHALL have port RstN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port AddrIn  input  AWIDTH  base byte address of next 4-pixel group from the address generator.
REQ-006 SHALL have port AddrClkIn  input  1  one-cycle strobe qualifying AddrIn, nominally every 4 cycles.
REQ-007 SHALL have ports IsActHorz, IsActVert  input  1 each  active-region flags from the address generator.
REQ-008 SHALL have port MemAddr  output  AWIDTH  registered read address to synchronous video RAM.
REQ-009 SHALL have port MemRd  output  1  registered read enable.
REQ-010 SHALL have port MemData  input  8  read data, valid one cycle after the edge at which MemRd/MemAddr were presented.
REQ-011 SHALL have port PixOut  output  PWIDTH  registered pixel {R[1:0],G[1:0],B[1:0]}, zero outside active video.
REQ-012 SHALL have ports Overrun, Underrun  output  1 each  sticky error flags.

Function
REQ-013 SHALL run FSM IDLE -> ISS0 -> ISS1 -> ISS2 -> DRAIN -> IDLE; AddrClkIn sampled high in IDLE or DRAIN moves to ISS0 and latches AddrIn as A.
REQ-014 SHALL drive MemRd=1 in ISS0/ISS1/ISS2 with MemAddr = A, A+1, A+2 respectively (mod 2^AWIDTH); MemRd=0, MemAddr held, otherwise.
REQ-015 SHALL capture MemData into staging bytes 0,1,2 on the edges one cycle after ISS0, ISS1, ISS2 (tracked via delayed MemRd and index), staging = {b2,b1,b0}.
REQ-016 SHALL load the 24-bit shift register from staging on the edge one cycle after each accepted AddrClkIn and, on that edge, present pixel 0 = staging[5:0]; pixels 1..3 = bits [11:6],[17:12],[23:18] on the three following edges.
REQ-017 SHALL give fixed latency: AddrClkIn sampled at edge E0 with address A -> pixel 0 of A on PixOut after edge E5, pixel 3 after E8, given next strobe at E4.
REQ-018 SHALL delay IsActHorz&IsActVert by the same 5 edges and force PixOut=0 when the delayed flag is low.
REQ-019 SHALL, on AddrClkIn sampled in ISS0/ISS1/ISS2, abort the fetch, restart at ISS0 with new A, discard partial staging, and set Overrun.
REQ-020 SHALL, when all 4 pixels have been shifted and no load occurs, output PixOut=0 and set Underrun while active; the first group after reset does not set Underrun.
REQ-021 SHALL clear Overrun/Underrun only by reset.

Reset
REQ-022 SHALL, while RstN=0, asynchronously force state IDLE, MemRd=0, MemAddr=0, PixOut=0, staging/shift register 0, pixel index 0, active delay line 0, Overrun=Underrun=0.
REQ-023 SHALL, on reset deassertion mid-fetch, resume from IDLE and emit zero pixels until the first completed group is loaded.

Structure
REQ-024 SHALL place FSM state encoding, PWIDTH and bytes-per-group (3) constants in the shared video package.
REQ-025 SHALL contain one natural sub-module, vpix_shift (24-bit load/shift pixel serializer with gating); fetch FSM stays in the top.

Verification
REQ-026 SHALL test: strobe every 4 cycles, A=0x0000, RAM[0..2]=0x41,0x10,0x04 -> PixOut 0x01,0x01,0x01,0x01 at E5..E8 when active.
REQ-027 SHALL test: A=0xFFFE -> MemAddr sequence 0xFFFE,0xFFFF,0x0000, no glitch on wrap.
REQ-028 SHALL test: second strobe 2 cycles after first -> Overrun=1, reads restart at new address, pixels of aborted group never appear.
REQ-029 SHALL test: strobes stop after one group -> 4 valid pixels, then PixOut=0 and Underrun=1 with active flags high.
REQ-030 SHALL test: IsActHorz low for one group -> that group's 4 pixels output 0, no error flags.
REQ-031 SHALL test: RstN pulsed low during ISS1 -> all outputs 0 immediately; after release, correct pixels from next strobe with latency 5.

Source files
------------

// File: rtl/vpix_fetch_pkg.sv
// Shared constants and types for the video pixel fetch block.
// Four RGB222 pixels are packed into three consecutive bytes of video RAM.
package vpix_fetch_pkg;

    localparam int PIX_WIDTH       = 6;
    localparam int BYTE_WIDTH      = 8;
    localparam int BYTES_PER_GROUP = 3;
    localparam int PIX_PER_GROUP   = 4;
    localparam int GROUP_BITS      = BYTES_PER_GROUP * BYTE_WIDTH;
    localparam int ACT_DELAY       = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISS0  = 3'd1,
        ISS1  = 3'd2,
        ISS2  = 3'd3,
        DRAIN = 3'd4
    } fetchState_e;

    // True in the three states that put a read on the memory bus.
    function automatic logic isIssue(input fetchState_e s);
        return (s == ISS0) || (s == ISS1) || (s == ISS2);
    endfunction

endpackage

// File: rtl/vpix_fetch_if.sv
// Read bus between the pixel fetch block and the synchronous video RAM.
// Data returns one cycle after the edge at which the read was presented.
interface vpix_fetch_if
    import vpix_fetch_pkg::*;
#(
    parameter int AWIDTH = 16
);

    logic [AWIDTH-1:0]     MemAddr;
    logic                  MemRd;
    logic [BYTE_WIDTH-1:0] MemData;

    modport master (
        output MemAddr,
        output MemRd,
        input  MemData
    );

    modport slave (
        input  MemAddr,
        input  MemRd,
        output MemData
    );

endinterface

// File: rtl/vpix_fetch_shift.sv
// Pixel serializer: takes one 24-bit group, emits four pixels on consecutive
// cycles, blanks outside active video and flags a sticky underrun when the
// group runs dry with nothing new to load.
module vpix_shift
    import vpix_fetch_pkg::*;
#(
    parameter int PWIDTH = PIX_WIDTH
)(
    input  logic                  PixelClk,
    input  logic                  RstN,
    input  logic                  load,
    input  logic [GROUP_BITS-1:0] loadData,
    input  logic                  actGate,
    output logic [PWIDTH-1:0]     pixOut,
    output logic                  underrun
);

    logic [GROUP_BITS-1:0] shReg;
    logic [1:0]            remain;
    logic                  primed;

    // Load a fresh group and show pixel 0, else shift out the rest, else blank.
    always_ff @(posedge PixelClk or negedge RstN) begin
        if (!RstN) begin
            shReg    <= '0;
            remain   <= 2'd0;
            primed   <= 1'b0;
            pixOut   <= '0;
            underrun <= 1'b0;
        end else if (load) begin
            pixOut <= actGate ? loadData[PWIDTH-1:0] : '0;
            shReg  <= loadData >> PWIDTH;
            remain <= 2'(PIX_PER_GROUP - 1);
            primed <= 1'b1;
        end else if (remain != 2'd0) begin
            pixOut <= actGate ? shReg[PWIDTH-1:0] : '0;
            shReg  <= shReg >> PWIDTH;
            remain <= remain - 2'd1;
        end else begin
            pixOut <= '0;
            if (primed && actGate) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vpix_fetch.sv
// Video pixel fetch: on each address strobe reads three bytes from video RAM,
// stages them, and hands the completed group to the serializer on the edge
// after the next strobe, giving a fixed five-edge strobe-to-pixel latency.
module vpix_fetch
    import vpix_fetch_pkg::*;
#(
    parameter int AWIDTH = 16,
    parameter int PWIDTH = PIX_WIDTH
)(
    input  logic              PixelClk,
    input  logic              RstN,
    input  logic [AWIDTH-1:0] AddrIn,
    input  logic              AddrClkIn,
    input  logic              IsActHorz,
    input  logic              IsActVert,
    vpix_fetch_if.master      mem,
    output logic [PWIDTH-1:0] PixOut,
    output logic              Overrun,
    output logic              Underrun
);

    fetchState_e           state;
    fetchState_e           nextState;
    logic                  accept;
    logic                  abort;
    logic [AWIDTH-1:0]     baseAddr;
    logic [1:0]            rdIdx;
    logic [1:0]            rdIdxDly;
    logic                  rdDly;
    logic [GROUP_BITS-1:0] staging;
    logic                  stagingValid;
    logic                  loadPend;
    logic [ACT_DELAY-1:0]  actPipe;
    logic                  shiftLoad;

    assign shiftLoad = loadPend && stagingValid;

    // Fetch state register.
    always_ff @(posedge PixelClk or negedge RstN) begin
        if (!RstN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state: a strobe always restarts at ISS0; mid-issue it aborts the fetch.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (AddrClkIn) begin
                    nextState = ISS0;
                    accept    = 1'b1;
                end
            end
            ISS0, ISS1, ISS2: begin
                if (AddrClkIn) begin
                    nextState = ISS0;
                    accept    = 1'b1;
                    abort     = 1'b1;
                end else if (state == ISS0) begin
                    nextState = ISS1;
                end else if (state == ISS1) begin
                    nextState = ISS2;
                end else begin
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (AddrClkIn) begin
                    nextState = ISS0;
                    accept    = 1'b1;
                end else begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Registered read request, decoded from the state being entered.
    always_ff @(posedge PixelClk or negedge RstN) begin
        if (!RstN) begin
            mem.MemRd   <= 1'b0;
            mem.MemAddr <= '0;
            baseAddr    <= '0;
            rdIdx       <= 2'd0;
        end else begin
            mem.MemRd <= isIssue(nextState);
            if (accept) begin
                baseAddr <= AddrIn;
            end
            case (nextState)
                ISS0: begin
                    mem.MemAddr <= AddrIn;
                    rdIdx       <= 2'd0;
                end
                ISS1: begin
                    mem.MemAddr <= baseAddr + AWIDTH'(1);
                    rdIdx       <= 2'd1;
                end
                ISS2: begin
                    mem.MemAddr <= baseAddr + AWIDTH'(2);
                    rdIdx       <= 2'd2;
                end
                default: begin
                end
            endcase
        end
    end

    // Capture returning bytes; an abort kills the in-flight read and clears staging.
    always_ff @(posedge PixelClk or negedge RstN) begin
        if (!RstN) begin
            rdDly        <= 1'b0;
            rdIdxDly     <= 2'd0;
            staging      <= '0;
            stagingValid <= 1'b0;
        end else begin
            rdDly    <= mem.MemRd && !abort;
            rdIdxDly <= rdIdx;
            if (shiftLoad) begin
                stagingValid <= 1'b0;
            end
            if (rdDly) begin
                case (rdIdxDly)
                    2'd0: staging[7:0]   <= mem.MemData;
                    2'd1: staging[15:8]  <= mem.MemData;
                    2'd2: begin
                        staging[23:16] <= mem.MemData;
                        stagingValid   <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            if (abort) begin
                staging      <= '0;
                stagingValid <= 1'b0;
            end
        end
    end

    // Load request, sticky overrun, and active-region delay matching pixel latency.
    always_ff @(posedge PixelClk or negedge RstN) begin
        if (!RstN) begin
            loadPend <= 1'b0;
            Overrun  <= 1'b0;
            actPipe  <= '0;
        end else begin
            loadPend <= accept;
            if (abort) begin
                Overrun <= 1'b1;
            end
            actPipe <= {actPipe[ACT_DELAY-2:0], IsActHorz & IsActVert};
        end
    end

    vpix_shift #(
        .PWIDTH (PWIDTH)
    ) uShift (
        .PixelClk (PixelClk),
        .RstN     (RstN),
        .load     (shiftLoad),
        .loadData (staging),
        .actGate  (actPipe[ACT_DELAY-1]),
        .pixOut   (PixOut),
        .underrun (Underrun)
    );

endmodule

// File: tb/tb_vpix_fetch.sv
// Directed testbench for vpix_fetch with a synchronous RAM model.
module tb_vpix_fetch;

    logic        PixelClk = 1'b0;
    logic        RstN     = 1'b1;
    logic [15:0] AddrIn   = 16'h0000;
    logic        AddrClkIn = 1'b0;
    logic        IsActHorz = 1'b0;
    logic        IsActVert = 1'b0;
    logic [5:0]  PixOut;
    logic        Overrun;
    logic        Underrun;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram [0:65535];

    vpix_fetch_if #(.AWIDTH(16)) memBus ();

    vpix_fetch #(
        .AWIDTH (16),
        .PWIDTH (6)
    ) dut (
        .PixelClk  (PixelClk),
        .RstN      (RstN),
        .AddrIn    (AddrIn),
        .AddrClkIn (AddrClkIn),
        .IsActHorz (IsActHorz),
        .IsActVert (IsActVert),
        .mem       (memBus.master),
        .PixOut    (PixOut),
        .Overrun   (Overrun),
        .Underrun  (Underrun)
    );

    // Free-running pixel clock.
    always #5 PixelClk = ~PixelClk;

    // Synchronous RAM: data valid one cycle after the read is sampled.
    always @(posedge PixelClk) begin
        if (memBus.MemRd) begin
            memBus.MemData <= ram[memBus.MemAddr];
        end
    end

    // Drive one cycle of inputs, let the edge sample them, settle 1 ns past it.
    task automatic applyStimulus(input logic strobe, input logic [15:0] addr,
                                 input logic actH, input logic actV);
        AddrClkIn = strobe;
        AddrIn    = addr;
        IsActHorz = actH;
        IsActVert = actV;
        @(posedge PixelClk);
        #1;
    endtask

    task automatic doReset();
        RstN      = 1'b0;
        AddrClkIn = 1'b0;
        AddrIn    = 16'h0000;
        IsActHorz = 1'b0;
        IsActVert = 1'b0;
        @(posedge PixelClk);
        #1;
        @(posedge PixelClk);
        #1;
        RstN = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        RstN = 1'b0;
        #1;
        total++;
        if ({memBus.MemRd, memBus.MemAddr, PixOut, Overrun, Underrun} !== 25'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h want=0",
                     {memBus.MemRd, memBus.MemAddr, PixOut, Overrun, Underrun});
        end
        doReset();
    endtask

    task automatic test_basic();
        logic [5:0]  expPix [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h01,
                                     6'h01, 6'h01, 6'h3F, 6'h2A, 6'h15, 6'h0C};
        logic [15:0] expAddr [4] = '{16'h0000, 16'h0001, 16'h0002, 16'h0002};
        logic        expRd [4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
        doReset();
        for (int k = 0; k < 13; k++) begin
            applyStimulus((k % 4 == 0) && (k <= 8), (k == 0) ? 16'h0000 : 16'h0010, 1'b1, 1'b1);
            total++;
            if (PixOut !== expPix[k]) begin
                bad++;
                $display("[TB] FAIL basic_pix E%0d got=%h want=%h", k, PixOut, expPix[k]);
            end
            if (k < 4) begin
                total++;
                if ({memBus.MemRd, memBus.MemAddr} !== {expRd[k], expAddr[k]}) begin
                    bad++;
                    $display("[TB] FAIL basic_rd E%0d got=%h want=%h", k,
                             {memBus.MemRd, memBus.MemAddr}, {expRd[k], expAddr[k]});
                end
            end
        end
        total++;
        if ({Overrun, Underrun} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL basic_flags got=%b want=00", {Overrun, Underrun});
        end
    endtask

    task automatic test_wrap();
        logic [5:0]  expPix [9]  = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                     6'h05, 6'h2B, 6'h13, 6'h10};
        logic [15:0] expAddr [5] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000, 16'h0010};
        logic        expRd [5]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        doReset();
        for (int k = 0; k < 9; k++) begin
            applyStimulus((k == 0) || (k == 4), (k == 0) ? 16'hFFFE : 16'h0010, 1'b1, 1'b1);
            if (k < 5) begin
                total++;
                if ({memBus.MemRd, memBus.MemAddr} !== {expRd[k], expAddr[k]}) begin
                    bad++;
                    $display("[TB] FAIL wrap_rd E%0d got=%h want=%h", k,
                             {memBus.MemRd, memBus.MemAddr}, {expRd[k], expAddr[k]});
                end
            end
            total++;
            if (PixOut !== expPix[k]) begin
                bad++;
                $display("[TB] FAIL wrap_pix E%0d got=%h want=%h", k, PixOut, expPix[k]);
            end
        end
    endtask

    task automatic test_overrun();
        logic [5:0]  expPix [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                     6'h00, 6'h3F, 6'h2A, 6'h15, 6'h0C};
        logic [15:0] expAddr [6] = '{16'h0020, 16'h0021, 16'h0010, 16'h0011, 16'h0012, 16'h0012};
        logic        expRd [6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        strobe;
        doReset();
        for (int k = 0; k < 11; k++) begin
            strobe = (k == 0) || (k == 2) || (k == 6) || (k == 10);
            applyStimulus(strobe, (k == 0) ? 16'h0020 : 16'h0010, 1'b1, 1'b1);
            total++;
            if (PixOut !== expPix[k]) begin
                bad++;
                $display("[TB] FAIL overrun_pix E%0d got=%h want=%h", k, PixOut, expPix[k]);
            end
            total++;
            if (Overrun !== (k >= 2)) begin
                bad++;
                $display("[TB] FAIL overrun_flag E%0d got=%b want=%b", k, Overrun, (k >= 2));
            end
            if (k < 6) begin
                total++;
                if ({memBus.MemRd, memBus.MemAddr} !== {expRd[k], expAddr[k]}) begin
                    bad++;
                    $display("[TB] FAIL overrun_rd E%0d got=%h want=%h", k,
                             {memBus.MemRd, memBus.MemAddr}, {expRd[k], expAddr[k]});
                end
            end
        end
        total++;
        if (Underrun !== 1'b0) begin
            bad++;
            $display("[TB] FAIL overrun_underrun got=%b want=0", Underrun);
        end
    endtask

    task automatic test_underrun();
        logic [5:0] expPix [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F,
                                    6'h2A, 6'h15, 6'h0C, 6'h00, 6'h00};
        doReset();
        for (int k = 0; k < 11; k++) begin
            applyStimulus((k == 0) || (k == 4), (k == 0) ? 16'h0010 : 16'h0000, 1'b1, 1'b1);
            total++;
            if (PixOut !== expPix[k]) begin
                bad++;
                $display("[TB] FAIL underrun_pix E%0d got=%h want=%h", k, PixOut, expPix[k]);
            end
            total++;
            if (Underrun !== (k >= 9)) begin
                bad++;
                $display("[TB] FAIL underrun_flag E%0d got=%b want=%b", k, Underrun, (k >= 9));
            end
        end
        total++;
        if (Overrun !== 1'b0) begin
            bad++;
            $display("[TB] FAIL underrun_overrun got=%b want=0", Overrun);
        end
    endtask

    task automatic test_inactive();
        logic [5:0] expPix [17] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F,
                                    6'h2A, 6'h15, 6'h0C, 6'h00, 6'h00, 6'h00,
                                    6'h00, 6'h01, 6'h01, 6'h01, 6'h01};
        doReset();
        for (int k = 0; k < 17; k++) begin
            applyStimulus((k % 4 == 0) && (k <= 12), (k < 8) ? 16'h0010 : 16'h0000,
                          !((k >= 4) && (k <= 7)), 1'b1);
            total++;
            if (PixOut !== expPix[k]) begin
                bad++;
                $display("[TB] FAIL inactive_pix E%0d got=%h want=%h", k, PixOut, expPix[k]);
            end
        end
        total++;
        if ({Overrun, Underrun} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL inactive_flags got=%b want=00", {Overrun, Underrun});
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] expPix [9] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                   6'h3F, 6'h2A, 6'h15, 6'h0C};
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus((k == 0) || (k == 4), 16'h0010, 1'b1, 1'b1);
        end
        total++;
        if (PixOut !== 6'h3F) begin
            bad++;
            $display("[TB] FAIL midreset_pre got=%h want=3f", PixOut);
        end
        RstN = 1'b0;
        #1;
        total++;
        if ({memBus.MemRd, memBus.MemAddr, PixOut, Overrun, Underrun} !== 25'd0) begin
            bad++;
            $display("[TB] FAIL midreset_clear got=%h want=0",
                     {memBus.MemRd, memBus.MemAddr, PixOut, Overrun, Underrun});
        end
        AddrClkIn = 1'b0;
        @(posedge PixelClk);
        #1;
        RstN = 1'b1;
        for (int k = 0; k < 9; k++) begin
            applyStimulus((k == 0) || (k == 4), (k == 0) ? 16'h0010 : 16'h0000, 1'b1, 1'b1);
            total++;
            if (PixOut !== expPix[k]) begin
                bad++;
                $display("[TB] FAIL midreset_pix E%0d got=%h want=%h", k, PixOut, expPix[k]);
            end
        end
        total++;
        if ({Overrun, Underrun} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL midreset_flags got=%b want=00", {Overrun, Underrun});
        end
    endtask

    // Watchdog so the run always ends on its own.
    initial begin
        #100000;
        $display("[TB] FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory image, then each scenario in turn.
    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'h00;
        end
        ram[16'h0000] = 8'h41;
        ram[16'h0001] = 8'h10;
        ram[16'h0002] = 8'h04;
        ram[16'h0010] = 8'hBF;
        ram[16'h0011] = 8'h5A;
        ram[16'h0012] = 8'h31;
        ram[16'h0020] = 8'h96;
        ram[16'h0021] = 8'h96;
        ram[16'h0022] = 8'h96;
        ram[16'hFFFE] = 8'hC5;
        ram[16'hFFFF] = 8'h3A;

        test_reset();
        test_basic();
        test_wrap();
        test_overrun();
        test_underrun();
        test_inactive();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
